uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver.
//  - Configurable data width, parity and stop bits; 3-sample majority vote per bit.
//  - Detects parity errors, framing errors and line break.
//  - Sits between the board RX pin and the command/packet layer of the smartwatch base.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sampler.sv | 50 +++++
 rtl/uart_rx_cfg.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the configurable UART receiver.
//   rx_state_t     receiver FSM state encoding
//   PARITY_*       values for the PARITY_MODE parameter
//   clog2_min1()   ceil(log2(v)), never less than 1 (safe counter width)
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input synchroniser, start-edge detect and 3-sample
// majority vote for the UART receiver.
//   clk, rst_n     system clock, asynchronous active-low reset
//   i_rx_serial    raw serial line (asynchronous, idle high)
//   i_clk_cnt      bit-phase counter from the receiver FSM
//   o_rx_s         synchronised line value
//   o_fall         rx_s is about to go 1 -> 0 on the next clock edge
//   o_vote         majority of the samples at counts H-1, H and the current
//                  rx_s; meaningful when i_clk_cnt == H+1
`timescale 1ns/1ps
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int H           = 108
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rx_serial,
    input  logic [CNT_W-1:0] i_clk_cnt,
    output logic             o_rx_s,
    output logic             o_fall,
    output logic             o_vote
);

    localparam logic [CNT_W-1:0] CNT_S0 = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_S1 = CNT_W'(H);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s0;
    logic                   r_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_s0   <= 1'b1;
            r_s1   <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_serial};
            if (i_clk_cnt == CNT_S0) r_s0 <= r_sync[SYNC_STAGES-1];
            if (i_clk_cnt == CNT_S1) r_s1 <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rx_s = r_sync[SYNC_STAGES-1];
    // Looking one stage ahead lets the FSM enter START on the very edge where
    // rx_s first reads 0, so clk_cnt = 0 lines up with the start of the bit.
    assign o_fall = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];
    assign o_vote = (r_s0 & r_s1) | (r_s0 & o_rx_s) | (r_s1 & o_rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (data bits, parity, stop bits)
// with majority-vote sampling, parity/framing error and break detection.
//   clk, rst_n     system clock, asynchronous active-low reset
//   i_rx_serial    serial line from the pin, idle high
//   o_rx_dv        one-cycle pulse: frame complete, data and flags valid
//   o_rx_data      last received word, held until the next o_rx_dv
//   o_parity_err   parity mismatch on the reported frame
//   o_frame_err    a stop bit of the reported frame was sampled low
//   o_break        every data, parity and stop bit of the frame was low
//   o_busy         FSM is not idle
`timescale 1ns/1ps
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx_serial,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int               CNT_W     = clog2_min1(CLKS_PER_BIT);
    localparam int               H         = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_DEC   = CNT_W'(H + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_all_low;
    logic                 r_dv;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_parity_err_o;
    logic                 r_frame_err_o;
    logic                 r_break_o;

    logic w_rx_s;
    logic w_fall;
    logic w_vote;
    logic w_decide;
    logic w_bit_end;
    logic w_par_exp;
    logic w_frame_bad;

    uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .H           (H)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx_serial (i_rx_serial),
        .i_clk_cnt   (r_clk_cnt),
        .o_rx_s      (w_rx_s),
        .o_fall      (w_fall),
        .o_vote      (w_vote)
    );

    assign w_decide    = (r_clk_cnt == CNT_DEC);
    assign w_bit_end   = (r_clk_cnt == CNT_LAST);
    assign w_par_exp   = (PARITY_MODE == PARITY_ODD) ? ~(^r_shift) : (^r_shift);
    // Includes the stop bit being decided right now.
    assign w_frame_bad = r_frame_err | ~w_vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_clk_cnt      <= '0;
            r_bit_idx      <= '0;
            r_shift        <= '0;
            r_parity_err   <= 1'b0;
            r_frame_err    <= 1'b0;
            r_all_low      <= 1'b0;
            r_dv           <= 1'b0;
            r_data         <= '0;
            r_parity_err_o <= 1'b0;
            r_frame_err_o  <= 1'b0;
            r_break_o      <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_fall) begin
                        r_state      <= ST_START;
                        r_parity_err <= 1'b0;
                        r_frame_err  <= 1'b0;
                        r_all_low    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_decide && w_vote) begin
                        r_state   <= ST_IDLE;   // false start
                        r_clk_cnt <= '0;
                    end else if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_clk_cnt <= '0;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    // LSB first: after DATA_BITS shifts bit i sits at index i.
                    if (w_decide) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (w_vote) r_all_low <= 1'b0;
                    end
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == DATA_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_decide) begin
                        if (w_vote != w_par_exp) r_parity_err <= 1'b1;
                        if (w_vote) r_all_low <= 1'b0;
                    end
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= ST_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_decide) begin
                        if (!w_vote) r_frame_err <= 1'b1;
                        if (w_vote) r_all_low <= 1'b0;
                    end
                    if (w_decide && (r_bit_idx == STOP_LAST)) begin
                        // Leave at mid-bit so a following start edge is not missed.
                        r_dv           <= 1'b1;
                        r_data         <= r_shift;
                        r_parity_err_o <= r_parity_err;
                        r_frame_err_o  <= w_frame_bad;
                        r_break_o      <= r_all_low & ~w_vote;
                        r_clk_cnt      <= '0;
                        r_bit_idx      <= '0;
                        r_state        <= w_frame_bad ? ST_WAIT_IDLE : ST_IDLE;
                    end else if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    // Needs a full bit time of continuous idle before re-arming.
                    if (!w_rx_s) begin
                        r_clk_cnt <= '0;
                    end else if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

    assign o_rx_dv      = r_dv;
    assign o_rx_data    = r_data;
    assign o_parity_err = r_parity_err_o;
    assign o_frame_err  = r_frame_err_o;
    assign o_break      = r_break_o;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg with three configurations
// (8N1, 7E1, 8N2) at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic line_a = 1'b1;
    logic line_b = 1'b1;
    logic line_c = 1'b1;

    always #5 clk = ~clk;

    logic       dv_a, perr_a, ferr_a, brk_a, busy_a;
    logic [7:0] data_a;
    logic       dv_b, perr_b, ferr_b, brk_b, busy_b;
    logic [6:0] data_b;
    logic       dv_c, perr_c, ferr_c, brk_c, busy_c;
    logic [7:0] data_c;

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .i_rx_serial(line_a), .o_rx_dv(dv_a), .o_rx_data(data_a),
        .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_break(brk_a), .o_busy(busy_a));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .i_rx_serial(line_b), .o_rx_dv(dv_b), .o_rx_data(data_b),
        .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_break(brk_b), .o_busy(busy_b));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .SYNC_STAGES(2)) u_c (
        .clk(clk), .rst_n(rst_n), .i_rx_serial(line_c), .o_rx_dv(dv_c), .o_rx_data(data_c),
        .o_parity_err(perr_c), .o_frame_err(ferr_c), .o_break(brk_c), .o_busy(busy_c));

    // dv pulse counters and a capture log for instance A
    int         n_a = 0;
    int         n_b = 0;
    int         n_c = 0;
    logic [7:0] cap_a [0:63];

    always @(posedge clk) begin
        if (dv_a) begin
            cap_a[n_a[5:0]] <= data_a;
            n_a <= n_a + 1;
        end
        if (dv_b) n_b <= n_b + 1;
        if (dv_c) n_c <= n_c + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       line_a = v;
            1:       line_b = v;
            default: line_c = v;
        endcase
    endtask

    // One frame: start, nbits data LSB first, optional parity (par < 0 = none),
    // nstop stop bits taken from stops[0..]. gbit >= 0 inverts the line for
    // one clock period at the middle of that frame bit.
    task automatic send(input int sel, input int nbits, input logic [8:0] data, input int par,
                        input logic [1:0] stops, input int nstop, input int bt, input int gbit);
        logic [15:0] bits;
        int n;
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin bits[n] = data[i]; n++; end
        if (par >= 0) begin bits[n] = par[0]; n++; end
        for (int i = 0; i < nstop; i++) begin bits[n] = stops[i]; n++; end
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            set_line(sel, bits[i]);
            if (i == gbit) begin
                #(bt / 2);
                set_line(sel, ~bits[i]);
                #10;
                set_line(sel, bits[i]);
                #(bt - bt / 2 - 10);
            end else begin
                #(bt);
            end
        end
        set_line(sel, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // reset state
        settle(3);
        chk("rst_dv_a", dv_a, 0);
        chk("rst_data_a", data_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_flags_a", {perr_a, ferr_a, brk_a}, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_data_c", data_c, 0);
        rst_n = 1'b1;
        settle(20);

        // 8N1 0xA5
        base = n_a;
        send(0, 8, 9'h0A5, -1, 2'b11, 1, 160, -1);
        settle(2);
        chk("t1_dv_count", n_a - base, 1);
        chk("t1_data", data_a, 8'hA5);
        chk("t1_flags", {perr_a, ferr_a, brk_a}, 0);
        chk("t1_busy", busy_a, 0);

        // 7E1: 0x35 has four ones, even parity bit = 0
        base = n_b;
        send(1, 7, 9'h035, 0, 2'b11, 1, 160, -1);
        settle(2);
        chk("t2_dv_count", n_b - base, 1);
        chk("t2_data", data_b, 7'h35);
        chk("t2_perr", perr_b, 0);
        chk("t2_ferr", ferr_b, 0);
        send(1, 7, 9'h035, 1, 2'b11, 1, 160, -1);
        settle(2);
        chk("t2b_dv_count", n_b - base, 2);
        chk("t2b_perr", perr_b, 1);
        chk("t2b_data", data_b, 7'h35);
        chk("t2b_ferr", ferr_b, 0);

        // 8N2 with the second stop bit low
        base = n_c;
        send(2, 8, 9'h03C, -1, 2'b01, 2, 160, -1);
        settle(2);
        chk("t3_dv_count", n_c - base, 1);
        chk("t3_ferr", ferr_c, 1);
        chk("t3_data", data_c, 8'h3C);
        chk("t3_brk_perr", {brk_c, perr_c}, 0);
        settle(30);
        chk("t3_busy_after", busy_c, 0);

        // break: line low for 40 bit times
        base = n_a;
        @(negedge clk);
        line_a = 1'b0;
        #(40 * 160);
        chk("t4_busy_held", busy_a, 1);
        line_a = 1'b1;
        settle(2);
        chk("t4_dv_count", n_a - base, 1);
        chk("t4_break", brk_a, 1);
        chk("t4_ferr", ferr_a, 1);
        chk("t4_data", data_a, 0);
        chk("t4_perr", perr_a, 0);
        settle(48);
        chk("t4_busy_idle", busy_a, 0);
        send(0, 8, 9'h055, -1, 2'b11, 1, 160, -1);
        settle(2);
        chk("t4b_dv_count", n_a - base, 2);
        chk("t4b_data", data_a, 8'h55);
        chk("t4b_flags", {ferr_a, brk_a}, 0);

        // 6-cycle low glitch in idle: false start
        base = n_a;
        @(negedge clk);
        line_a = 1'b0;
        #60;
        chk("t5_busy_glitch", busy_a, 1);
        line_a = 1'b1;
        settle(16);
        chk("t5_busy_back", busy_a, 0);
        chk("t5_no_dv", n_a - base, 0);

        // one-cycle glitch at mid of data bit 3 (frame bit 4) of 0xFF
        send(0, 8, 9'h0FF, -1, 2'b11, 1, 160, 4);
        settle(2);
        chk("t5b_dv_count", n_a - base, 1);
        chk("t5b_data", data_a, 8'hFF);
        chk("t5b_ferr", ferr_a, 0);

        // back-to-back at +3% then -3% bit time
        base = n_a;
        send(0, 8, 9'h012, -1, 2'b11, 1, 165, -1);
        send(0, 8, 9'h034, -1, 2'b11, 1, 155, -1);
        settle(2);
        chk("t6_dv_count", n_a - base, 2);
        chk("t6_first", cap_a[base[5:0]], 8'h12);
        base = base + 1;
        chk("t6_second", cap_a[base[5:0]], 8'h34);
        chk("t6_flags", {perr_a, ferr_a, brk_a}, 0);

        // reset in the middle of DATA of a third byte (0x56)
        base = n_a;
        @(negedge clk);
        line_a = 1'b0; #160;
        line_a = 1'b0; #160;
        line_a = 1'b1; #160;
        line_a = 1'b1; #80;
        chk("t6r_busy_mid", busy_a, 1);
        rst_n = 1'b0;
        #3;
        chk("t6r_dv", dv_a, 0);
        chk("t6r_data", data_a, 0);
        chk("t6r_busy", busy_a, 0);
        chk("t6r_flags", {perr_a, ferr_a, brk_a}, 0);
        line_a = 1'b1;
        settle(5);
        rst_n = 1'b1;
        settle(16 * 12);
        chk("t6r_no_dv", n_a - base, 0);
        chk("t6r_busy_after", busy_a, 0);
        chk("t6r_data_after", data_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
